// File: rtl/rr_logging_bus_pack2unpack_pkg.sv
// Shared types for the logging-bus packer/unpacker pair: channel width encoding
// and the slot-offset helper that both sides use to agree on the unpacked layout.
package rr_logging_bus_pack2unpack_pkg;

    localparam int unsigned RR_CHANNEL_WIDTH_BITS = 32;
    localparam int unsigned RR_MAX_CHANNELS       = 16;
    localparam int unsigned RR_WIDTHS_FLAT_BITS   = RR_MAX_CHANNELS * RR_CHANNEL_WIDTH_BITS;

    typedef logic [RR_WIDTHS_FLAT_BITS-1:0] rr_widths_flat_t;

    // Bit offset of channel idx in the unpacked layout (sum of all lower widths).
    function automatic int unsigned get_offset(input rr_widths_flat_t widths, input int unsigned idx);
        int unsigned sum;
        sum = 0;
        for (int unsigned i = 0; i < RR_MAX_CHANNELS; i++) begin
            if (i < idx) begin
                sum += widths[i*RR_CHANNEL_WIDTH_BITS +: RR_CHANNEL_WIDTH_BITS];
            end
        end
        return sum;
    endfunction

endpackage

// File: rtl/rr_logging_bus_pack2unpack_if.sv
// Packed-record input and unpacked-record output handshakes of the replay unpacker.
interface rr_logging_bus_pack2unpack_if #(
    parameter int unsigned LOGB_CHANNEL_CNT = 2,
    parameter int unsigned LOGE_CHANNEL_CNT = 1,
    parameter int unsigned FULL_WIDTH       = 24,
    parameter int unsigned OFFSET_WIDTH     = $clog2(FULL_WIDTH + 1)
);
    logic                        in_valid;
    logic                        in_ready;
    logic [LOGB_CHANNEL_CNT-1:0] in_logb_valid;
    logic [LOGE_CHANNEL_CNT-1:0] in_loge_valid;
    logic [FULL_WIDTH-1:0]       in_data;
    logic [OFFSET_WIDTH-1:0]     in_len;
    logic                        out_valid;
    logic                        out_ready;
    logic [LOGB_CHANNEL_CNT-1:0] out_logb_valid;
    logic [LOGE_CHANNEL_CNT-1:0] out_loge_valid;
    logic [FULL_WIDTH-1:0]       out_logb_data;
    logic                        len_err;

    modport master (
        output in_valid, in_logb_valid, in_loge_valid, in_data, in_len, out_ready,
        input  in_ready, out_valid, out_logb_valid, out_loge_valid, out_logb_data, len_err
    );

    modport slave (
        input  in_valid, in_logb_valid, in_loge_valid, in_data, in_len, out_ready,
        output in_ready, out_valid, out_logb_valid, out_loge_valid, out_logb_data, len_err
    );
endinterface

// File: rtl/rr_logging_bus_pack2unpack_stage.sv
// One elastic pipeline stage: moves logb channel IDX from the bottom of the
// remaining packed data into its fixed slot of the unpacked accumulator.
module rr_unpack_stage #(
    parameter int unsigned IDX              = 0,
    parameter int unsigned W                = 8,
    parameter int unsigned OFF              = 0,
    parameter int unsigned FULL_WIDTH       = 24,
    parameter int unsigned OFFSET_WIDTH     = 5,
    parameter int unsigned LOGB_CHANNEL_CNT = 2,
    parameter int unsigned LOGE_CHANNEL_CNT = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        up_valid,
    output logic                        up_ready,
    input  logic [LOGB_CHANNEL_CNT-1:0] up_logb,
    input  logic [LOGE_CHANNEL_CNT-1:0] up_loge,
    input  logic [FULL_WIDTH-1:0]       up_rem,
    input  logic [FULL_WIDTH-1:0]       up_acc,
    input  logic [OFFSET_WIDTH-1:0]     up_cnt,
    input  logic [OFFSET_WIDTH-1:0]     up_len,
    output logic                        dn_valid,
    input  logic                        dn_ready,
    output logic [LOGB_CHANNEL_CNT-1:0] dn_logb,
    output logic [LOGE_CHANNEL_CNT-1:0] dn_loge,
    output logic [FULL_WIDTH-1:0]       dn_rem,
    output logic [FULL_WIDTH-1:0]       dn_acc,
    output logic [OFFSET_WIDTH-1:0]     dn_cnt,
    output logic [OFFSET_WIDTH-1:0]     dn_len
);
    logic [FULL_WIDTH-1:0]   rem_nxt;
    logic [FULL_WIDTH-1:0]   acc_nxt;
    logic [OFFSET_WIDTH-1:0] cnt_nxt;

    // Bubble-collapsing ready: an empty stage always accepts.
    assign up_ready = !dn_valid || dn_ready;

    always_comb begin
        rem_nxt = up_rem;
        acc_nxt = up_acc;
        cnt_nxt = up_cnt;
        if (up_logb[IDX]) begin
            acc_nxt[OFF +: W] = up_rem[W-1:0];
            rem_nxt           = up_rem >> W;
            cnt_nxt           = up_cnt + OFFSET_WIDTH'(W);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dn_valid <= 1'b0;
            dn_logb  <= '0;
            dn_loge  <= '0;
            dn_rem   <= '0;
            dn_acc   <= '0;
            dn_cnt   <= '0;
            dn_len   <= '0;
        end else if (up_ready) begin
            dn_valid <= up_valid;
            if (up_valid) begin
                dn_logb <= up_logb;
                dn_loge <= up_loge;
                dn_rem  <= rem_nxt;
                dn_acc  <= acc_nxt;
                dn_cnt  <= cnt_nxt;
                dn_len  <= up_len;
            end
        end
    end
endmodule

// File: rtl/rr_logging_bus_pack2unpack.sv
// Replay-side unpacker: restores the fixed-offset per-channel layout from a dense
// packed logging record, one pipeline stage per logb channel, plus a sticky length check.
module rr_logging_bus_pack2unpack
    import rr_logging_bus_pack2unpack_pkg::*;
#(
    parameter int unsigned LOGB_CHANNEL_CNT = 2,
    parameter int unsigned LOGE_CHANNEL_CNT = 1,
    parameter logic [LOGB_CHANNEL_CNT-1:0][RR_CHANNEL_WIDTH_BITS-1:0] CHANNEL_WIDTHS = {32'd16, 32'd8},
    parameter int unsigned FULL_WIDTH       = 24,
    parameter int unsigned OFFSET_WIDTH     = $clog2(FULL_WIDTH + 1)
) (
    input logic                        clk,
    input logic                        rst,
    rr_logging_bus_pack2unpack_if.slave bus
);
    localparam int unsigned N = LOGB_CHANNEL_CNT;
    localparam rr_widths_flat_t WIDTHS_FLAT = RR_WIDTHS_FLAT_BITS'(CHANNEL_WIDTHS);

    if (get_offset(WIDTHS_FLAT, N) != FULL_WIDTH) begin : g_width_check
        $error("rr_logging_bus_pack2unpack: sum of CHANNEL_WIDTHS differs from FULL_WIDTH");
    end

    // Element k is the input of stage k; element N is the last stage's output.
    logic                        st_valid [N+1];
    logic [N-1:0]                st_logb  [N+1];
    logic [LOGE_CHANNEL_CNT-1:0] st_loge  [N+1];
    logic [FULL_WIDTH-1:0]       st_rem   [N+1];
    logic [FULL_WIDTH-1:0]       st_acc   [N+1];
    logic [OFFSET_WIDTH-1:0]     st_cnt   [N+1];
    logic [OFFSET_WIDTH-1:0]     st_len   [N+1];
    logic                        len_err_q;

    assign st_valid[0] = bus.in_valid;
    assign st_logb[0]  = bus.in_logb_valid;
    assign st_loge[0]  = bus.in_loge_valid;
    assign st_rem[0]   = bus.in_data;
    assign st_acc[0]   = '0;
    assign st_cnt[0]   = '0;
    assign st_len[0]   = bus.in_len;

    for (genvar k = 0; k < N; k++) begin : g_stage
        logic up_rdy;
        logic dn_rdy;

        if (k == N - 1) begin : g_last
            assign dn_rdy = bus.out_ready;
        end else begin : g_mid
            assign dn_rdy = g_stage[k+1].up_rdy;
        end

        rr_unpack_stage #(
            .IDX              (k),
            .W                (CHANNEL_WIDTHS[k]),
            .OFF              (get_offset(WIDTHS_FLAT, k)),
            .FULL_WIDTH       (FULL_WIDTH),
            .OFFSET_WIDTH     (OFFSET_WIDTH),
            .LOGB_CHANNEL_CNT (N),
            .LOGE_CHANNEL_CNT (LOGE_CHANNEL_CNT)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .up_valid (st_valid[k]),
            .up_ready (up_rdy),
            .up_logb  (st_logb[k]),
            .up_loge  (st_loge[k]),
            .up_rem   (st_rem[k]),
            .up_acc   (st_acc[k]),
            .up_cnt   (st_cnt[k]),
            .up_len   (st_len[k]),
            .dn_valid (st_valid[k+1]),
            .dn_ready (dn_rdy),
            .dn_logb  (st_logb[k+1]),
            .dn_loge  (st_loge[k+1]),
            .dn_rem   (st_rem[k+1]),
            .dn_acc   (st_acc[k+1]),
            .dn_cnt   (st_cnt[k+1]),
            .dn_len   (st_len[k+1])
        );
    end

    assign bus.in_ready       = g_stage[0].up_rdy;
    assign bus.out_valid      = st_valid[N];
    assign bus.out_logb_valid = st_logb[N];
    assign bus.out_loge_valid = st_loge[N];
    assign bus.out_logb_data  = st_acc[N];
    assign bus.len_err        = len_err_q;

    // Sticky flag: a record left with a consumed bit count that disagrees with its len.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_err_q <= 1'b0;
        end else if (st_valid[N] && bus.out_ready && (st_cnt[N] != st_len[N])) begin
            len_err_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_rr_logging_bus_pack2unpack.sv
// Directed bench: default {16,8} unpacker via a vector table plus streaming/reset
// sequences, and a single 32-bit channel instance checked against a small model.
module tb_rr_logging_bus_pack2unpack;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    rr_logging_bus_pack2unpack_if #(.LOGB_CHANNEL_CNT(2), .LOGE_CHANNEL_CNT(1), .FULL_WIDTH(24), .OFFSET_WIDTH(5)) bus_a ();
    rr_logging_bus_pack2unpack_if #(.LOGB_CHANNEL_CNT(1), .LOGE_CHANNEL_CNT(1), .FULL_WIDTH(32), .OFFSET_WIDTH(6)) bus_b ();

    rr_logging_bus_pack2unpack #(
        .LOGB_CHANNEL_CNT (2),
        .LOGE_CHANNEL_CNT (1),
        .CHANNEL_WIDTHS   ({32'd16, 32'd8}),
        .FULL_WIDTH       (24),
        .OFFSET_WIDTH     (5)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    rr_logging_bus_pack2unpack #(
        .LOGB_CHANNEL_CNT (1),
        .LOGE_CHANNEL_CNT (1),
        .CHANNEL_WIDTHS   (32'd32),
        .FULL_WIDTH       (32),
        .OFFSET_WIDTH     (6)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  logb;
        logic        loge;
        logic [23:0] data;
        logic [4:0]  len;
        logic [23:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference unpack for widths ch0=8, ch1=16.
    function automatic logic [23:0] model_a(input logic [1:0] logb, input logic [23:0] d);
        logic [23:0] r;
        logic [23:0] o;
        r = d;
        o = '0;
        if (logb[0]) begin
            o[7:0] = r[7:0];
            r      = r >> 8;
        end
        if (logb[1]) o[23:8] = r[15:0];
        return o;
    endfunction

    function automatic logic [4:0] len_a(input logic [1:0] logb);
        return (logb[0] ? 5'd8 : 5'd0) + (logb[1] ? 5'd16 : 5'd0);
    endfunction

    task automatic drive_a(input logic v, input logic [1:0] logb, input logic loge,
                           input logic [23:0] data, input logic [4:0] len);
        bus_a.in_valid      = v;
        bus_a.in_logb_valid = logb;
        bus_a.in_loge_valid = loge;
        bus_a.in_data       = data;
        bus_a.in_len        = len;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [23:0] exp_q [$];
        logic [1:0]  expb_q [$];
        logic [23:0] prev_data;
        logic        prev_stall;
        logic        in_fire;
        logic        out_fire;
        logic [1:0]  lb;
        logic [23:0] d;
        logic [31:0] b_data;
        logic        b_logb;
        logic        b_loge;
        logic [31:0] b_exp;
        logic        b_exp_logb;
        logic        b_exp_loge;
        int          sent;
        int          got;
        int          occ;

        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        drive_a(1'b0, 2'b00, 1'b0, 24'h0, 5'd0);
        bus_a.out_ready     = 1'b1;
        bus_b.in_valid      = 1'b0;
        bus_b.in_logb_valid = 1'b0;
        bus_b.in_loge_valid = 1'b0;
        bus_b.in_data       = 32'h0;
        bus_b.in_len        = 6'd0;
        bus_b.out_ready     = 1'b1;

        vecs[0] = '{2'b11, 1'b0, 24'hABCD12, 5'd24, 24'hABCD12, 1'b0};
        vecs[1] = '{2'b10, 1'b0, 24'h005A5A, 5'd16, 24'h5A5A00, 1'b0};
        vecs[2] = '{2'b01, 1'b1, 24'hFFFF34, 5'd8,  24'h000034, 1'b0};
        vecs[3] = '{2'b00, 1'b1, 24'h123456, 5'd0,  24'h000000, 1'b0};
        vecs[4] = '{2'b00, 1'b1, 24'h000000, 5'd5,  24'h000000, 1'b1};
        vecs[5] = '{2'b11, 1'b0, 24'hFFFFEE, 5'd24, 24'hFFFFEE, 1'b1};

        tick();
        tick();
        check("reset_out_valid", 64'(bus_a.out_valid), 64'd0);
        check("reset_out_data", 64'(bus_a.out_logb_data), 64'd0);
        check("reset_out_logb", 64'(bus_a.out_logb_valid), 64'd0);
        check("reset_len_err", 64'(bus_a.len_err), 64'd0);
        rst = 1'b0;
        tick();
        check("reset_in_ready", 64'(bus_a.in_ready), 64'd1);

        // Single records through the idle pipeline: latency 2, then drained.
        for (int i = 0; i < 6; i++) begin
            drive_a(1'b1, vecs[i].logb, vecs[i].loge, vecs[i].data, vecs[i].len);
            check($sformatf("vec%0d_in_ready", i), 64'(bus_a.in_ready), 64'd1);
            tick();
            bus_a.in_valid = 1'b0;
            check($sformatf("vec%0d_early_valid", i), 64'(bus_a.out_valid), 64'd0);
            tick();
            check($sformatf("vec%0d_out_valid", i), 64'(bus_a.out_valid), 64'd1);
            check($sformatf("vec%0d_data", i), 64'(bus_a.out_logb_data), 64'(vecs[i].exp_data));
            check($sformatf("vec%0d_logb", i), 64'(bus_a.out_logb_valid), 64'(vecs[i].logb));
            check($sformatf("vec%0d_loge", i), 64'(bus_a.out_loge_valid), 64'(vecs[i].loge));
            tick();
            check($sformatf("vec%0d_len_err", i), 64'(bus_a.len_err), 64'(vecs[i].exp_err));
            check($sformatf("vec%0d_drained", i), 64'(bus_a.out_valid), 64'd0);
        end

        // Streaming 8 records with out_ready pattern 1,0,0 repeating.
        pulse_reset();
        sent       = 0;
        got        = 0;
        occ        = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
            lb = 2'(sent);
            d  = {8'(8'hA0 + sent), 8'(8'h50 + sent), 8'(8'h10 + sent)};
            drive_a(sent < 8, lb, 1'(sent), d, len_a(lb));
            bus_a.out_ready = (cyc % 3 == 0);
            #1;
            check("stream_in_ready", 64'(bus_a.in_ready), 64'((occ < 2) || bus_a.out_ready));
            if (prev_stall) begin
                check("stall_valid_hold", 64'(bus_a.out_valid), 64'd1);
                check("stall_data_hold", 64'(bus_a.out_logb_data), 64'(prev_data));
            end
            in_fire  = bus_a.in_valid && bus_a.in_ready;
            out_fire = bus_a.out_valid && bus_a.out_ready;
            if (out_fire) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL stream_extra: unexpected record %0h", bus_a.out_logb_data);
                end else begin
                    check("stream_data", 64'(bus_a.out_logb_data), 64'(exp_q.pop_front()));
                    check("stream_logb", 64'(bus_a.out_logb_valid), 64'(expb_q.pop_front()));
                end
                got++;
            end
            if (in_fire) begin
                exp_q.push_back(model_a(lb, d));
                expb_q.push_back(lb);
                sent++;
            end
            occ        = occ + int'(in_fire) - int'(out_fire);
            prev_stall = bus_a.out_valid && !bus_a.out_ready;
            prev_data  = bus_a.out_logb_data;
            @(posedge clk);
            #1;
        end
        bus_a.in_valid  = 1'b0;
        bus_a.out_ready = 1'b1;
        check("stream_count", 64'(got), 64'd8);
        check("stream_queue_empty", 64'(exp_q.size()), 64'd0);
        tick();
        check("stream_no_dup", 64'(bus_a.out_valid), 64'd0);
        check("stream_len_err", 64'(bus_a.len_err), 64'd0);

        // Reset with two records in flight and len_err set.
        drive_a(1'b1, 2'b00, 1'b1, 24'h0, 5'd5);
        tick();
        bus_a.in_valid = 1'b0;
        tick();
        tick();
        check("rst_pre_err", 64'(bus_a.len_err), 64'd1);
        bus_a.out_ready = 1'b0;
        drive_a(1'b1, 2'b11, 1'b0, 24'h111111, 5'd24);
        tick();
        drive_a(1'b1, 2'b11, 1'b0, 24'h222222, 5'd24);
        tick();
        bus_a.in_valid = 1'b0;
        check("rst_pre_full_ready", 64'(bus_a.in_ready), 64'd0);
        check("rst_pre_valid", 64'(bus_a.out_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_valid", 64'(bus_a.out_valid), 64'd0);
        check("rst_async_err", 64'(bus_a.len_err), 64'd0);
        check("rst_async_data", 64'(bus_a.out_logb_data), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        drive_a(1'b1, 2'b01, 1'b0, 24'h0000C7, 5'd8);
        bus_a.out_ready = 1'b1;
        check("post_rst_in_ready", 64'(bus_a.in_ready), 64'd1);
        tick();
        bus_a.in_valid = 1'b0;
        check("post_rst_lat1", 64'(bus_a.out_valid), 64'd0);
        tick();
        check("post_rst_lat2", 64'(bus_a.out_valid), 64'd1);
        check("post_rst_data", 64'(bus_a.out_logb_data), 64'h0000C7);
        tick();
        check("post_rst_empty", 64'(bus_a.out_valid), 64'd0);

        // Single 32-bit channel: latency 1, full rate, 100 random records.
        b_exp      = '0;
        b_exp_logb = 1'b0;
        b_exp_loge = 1'b0;
        for (int i = 0; i <= 100; i++) begin
            b_logb = 1'($urandom_range(0, 1));
            b_loge = 1'($urandom_range(0, 1));
            b_data = $urandom;
            bus_b.in_valid      = (i < 100);
            bus_b.in_logb_valid = b_logb;
            bus_b.in_loge_valid = b_loge;
            bus_b.in_data       = b_data;
            bus_b.in_len        = b_logb ? 6'd32 : 6'd0;
            bus_b.out_ready     = 1'b1;
            #1;
            check("b_in_ready", 64'(bus_b.in_ready), 64'd1);
            if (i == 0) begin
                check("b_idle", 64'(bus_b.out_valid), 64'd0);
            end else begin
                check("b_out_valid", 64'(bus_b.out_valid), 64'd1);
                check("b_data", 64'(bus_b.out_logb_data), 64'(b_exp));
                check("b_logb", 64'(bus_b.out_logb_valid), 64'(b_exp_logb));
                check("b_loge", 64'(bus_b.out_loge_valid), 64'(b_exp_loge));
            end
            b_exp      = b_logb ? b_data : 32'h0;
            b_exp_logb = b_logb;
            b_exp_loge = b_loge;
            @(posedge clk);
            #1;
        end
        bus_b.in_valid = 1'b0;
        check("b_drained", 64'(bus_b.out_valid), 64'd0);
        check("b_len_err", 64'(bus_b.len_err), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
